alarm_sched: RTL
================

# alarm_sched

Multi-slot alarm scheduler for the RTC interrupt path. It holds NUM_SLOTS programmable alarm entries and time-shares a single time comparator across them. On each seconds tick it scans the slots once, one per cycle, and latches a pending flag for every enabled slot that matches. It presents a level interrupt with the lowest pending slot index to the interrupt controller, and pending flags are cleared by an acknowledge handshake.

## Interface
- NUM_SLOTS, 4, number of alarm slots; legal range 2..8
- SLOT_W, $clog2(NUM_SLOTS), slot index width; derived, not overridden
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- sec_tick_i  in  1  one-cycle pulse; current-time inputs are valid and stable from this cycle until the next tick
- cur_sec_i / cur_min_i / cur_hour_i  in  6 each  current time
- cur_day_of_week_i  in  3  current weekday
- wr_en_i  in  1  slot write strobe
- wr_slot_i  in  SLOT_W  slot index to write
- wr_sec_i / wr_min_i / wr_hour_i  in  6 each  alarm time fields
- wr_day_of_week_i  in  3  alarm weekday
- wr_mask_i  in  4  per-field don't-care: bit0 sec, bit1 min, bit2 hour, bit3 dow
- wr_enable_i  in  1  slot enable value written with the entry
- ack_i  in  1  acknowledge strobe
- ack_slot_i  in  SLOT_W  slot index whose pending flag is cleared
- irq_o  out  1  OR of all pending flags
- irq_slot_o  out  SLOT_W  lowest-index pending slot; 0 when none is pending
- pending_o  out  NUM_SLOTS  pending flags
- busy_o  out  1  scan in progress
- overrun_o  out  1  sticky; a tick arrived during a scan

## Operation
- Reset values:
  - all slot entries cleared, including enable = 0
  - pending = 0; irq_o, irq_slot_o, busy_o and overrun_o = 0
  - FSM in IDLE; scan index = 0
- FSM states are IDLE and SCAN.
- IDLE to SCAN happens on sec_tick_i. On that edge the block:
  - snapshots cur_* into shadow registers
  - sets the scan index to 0
- Each SCAN cycle compares slot[idx] against the snapshot.
  - The slot matches when it is enabled and every field with a 0 mask bit is equal.
  - A match sets pending[idx].
  - A fully masked enabled slot matches on every tick.
- idx increments each SCAN cycle. When idx = NUM_SLOTS-1, the FSM returns to IDLE.
- A tick arriving while in SCAN is dropped and sets overrun_o. overrun_o clears only on reset.
- A write replaces the addressed slot's entry and clears that slot's pending flag. Writes are accepted in any state.
- A write and a compare of the same slot in the same cycle:
  - the compare uses the old entry
  - the write's pending clear wins over the set
- ack_i clears pending[ack_slot_i].
  - An ack and a compare set on the same slot in the same cycle: the set wins.
  - An ack of a non-pending slot has no effect.
- irq_o and irq_slot_o are combinational from the pending register.
- Out-of-range wr_slot_i or ack_slot_i (≥ NUM_SLOTS) is ignored.
- Reset asserted mid-scan aborts the scan immediately and restores all reset values.

## Timing
- The tick is sampled at edge T. busy_o is high for cycles T+1 .. T+NUM_SLOTS.
- Slot k is compared in cycle T+1+k. Its pending flag and irq_o are visible from cycle T+2+k.
- A tick in cycle T+1+NUM_SLOTS or later starts a new scan with no penalty. A tick during the busy window is an overrun.
- Write-to-effect latency is one cycle. A slot written at edge W is used by any compare in cycle W+1 or later.
- Ack-to-clear latency is one cycle. irq_o drops the cycle after the ack of the last pending slot.

## Configuration
- ALARM_SCHED_DOW_EN defined:
  - the day-of-week field is stored per slot
  - it is compared under mask bit 3
- ALARM_SCHED_DOW_EN undefined:
  - the dow storage and snapshot are removed
  - the ports stay present, but cur_day_of_week_i, wr_day_of_week_i and wr_mask_i[3] are ignored
  - dow is treated as always masked

## Test plan
- Reset test: assert rst_i mid-scan → all outputs 0 in the same cycle; after release, no scan starts until the next tick.
- Single-slot match:
  - setup: slot 2 = 12:30:15, mask 0, enabled; tick with cur = 12:30:15
  - required: busy_o high 4 cycles, pending_o = 4'b0100 from T+4, irq_o = 1, irq_slot_o = 2
  - then ack_slot_i = 2 → irq_o = 0 one cycle later
- Multi-match and priority:
  - setup: slots 1 and 3 fully masked, enabled
  - tick → pending_o = 4'b1010 and irq_slot_o = 1
  - ack 1 → irq_slot_o = 3
- Collisions:
  - ack_slot_i = 0 in the compare cycle of matching slot 0 → pending[0] stays 1
  - write to slot 0 in that cycle → pending[0] = 0
- Overrun: a second tick at T+2 with NUM_SLOTS = 4 → scan is not restarted and overrun_o = 1 permanently.
- DOW masking:
  - setup: slot 0 = 08:00:00, dow 3, mask 4'b0000; tick with dow 5
  - with ALARM_SCHED_DOW_EN: no pending
  - without it: pending_o[0] = 1

Source files
------------

// File: rtl/alarm_sched.sv
// alarm_sched: multi-slot RTC alarm scheduler.
// One time comparator is shared across NUM_SLOTS alarm slots. Each seconds
// tick starts a scan that visits one slot per cycle. Pending flags are set on
// a match and cleared by an ack or by rewriting the slot.
// Optional feature macro: ALARM_SCHED_DOW_EN (per-slot day-of-week field).

// Storage for one alarm entry; the whole entry is replaced on a write.
module alarm_slot (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_i,
    input  logic [5:0] wr_sec_i,
    input  logic [5:0] wr_min_i,
    input  logic [5:0] wr_hour_i,
    input  logic [2:0] wr_dow_i,
    input  logic [3:0] wr_mask_i,
    input  logic       wr_enable_i,
    output logic [5:0] sec_o,
    output logic [5:0] min_o,
    output logic [5:0] hour_o,
    output logic [2:0] dow_o,
    output logic [3:0] mask_o,
    output logic       en_o
);
    logic [5:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [2:0] mask_q, mask_d;
    logic       en_q, en_d;

    // Next entry: hold, or take the written fields
    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        mask_d = mask_q;
        en_d   = en_q;
        if (wr_i) begin
            sec_d  = wr_sec_i;
            min_d  = wr_min_i;
            hour_d = wr_hour_i;
            mask_d = wr_mask_i[2:0];
            en_d   = wr_enable_i;
        end
    end

    // Entry registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
            mask_q <= '0;
            en_q   <= 1'b0;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            mask_q <= mask_d;
            en_q   <= en_d;
        end
    end

`ifdef ALARM_SCHED_DOW_EN
    logic [2:0] dow_q, dow_d;
    logic       dmask_q, dmask_d;

    // Day-of-week field and its mask bit
    always_comb begin
        dow_d   = dow_q;
        dmask_d = dmask_q;
        if (wr_i) begin
            dow_d   = wr_dow_i;
            dmask_d = wr_mask_i[3];
        end
    end

    // Day-of-week registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dow_q   <= '0;
            dmask_q <= 1'b0;
        end else begin
            dow_q   <= dow_d;
            dmask_q <= dmask_d;
        end
    end

    assign dow_o  = dow_q;
    assign mask_o = {dmask_q, mask_q};
`else
    // No weekday storage: the field always reads as masked.
    logic unused_dow;
    assign unused_dow = ^{wr_dow_i, wr_mask_i[3]};
    assign dow_o  = '0;
    assign mask_o = {1'b1, mask_q};
`endif

    assign sec_o  = sec_q;
    assign min_o  = min_q;
    assign hour_o = hour_q;
    assign en_o   = en_q;
endmodule

module alarm_sched #(
    parameter int  NUM_SLOTS = 4,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sec_tick_i,
    input  logic [5:0]           cur_sec_i,
    input  logic [5:0]           cur_min_i,
    input  logic [5:0]           cur_hour_i,
    input  logic [2:0]           cur_day_of_week_i,
    input  logic                 wr_en_i,
    input  logic [SLOT_W-1:0]    wr_slot_i,
    input  logic [5:0]           wr_sec_i,
    input  logic [5:0]           wr_min_i,
    input  logic [5:0]           wr_hour_i,
    input  logic [2:0]           wr_day_of_week_i,
    input  logic [3:0]           wr_mask_i,
    input  logic                 wr_enable_i,
    input  logic                 ack_i,
    input  logic [SLOT_W-1:0]    ack_slot_i,
    output logic                 irq_o,
    output logic [SLOT_W-1:0]    irq_slot_o,
    output logic [NUM_SLOTS-1:0] pending_o,
    output logic                 busy_o,
    output logic                 overrun_o
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t                  state_q, state_d;
    logic [SLOT_W-1:0]       idx_q, idx_d;
    logic [NUM_SLOTS-1:0]    pending_q, pending_d;
    logic                    overrun_q, overrun_d;
    logic [5:0]              snap_sec_q, snap_sec_d;
    logic [5:0]              snap_min_q, snap_min_d;
    logic [5:0]              snap_hour_q, snap_hour_d;
    logic [2:0]              snap_dow;

    logic [NUM_SLOTS-1:0][5:0] s_sec, s_min, s_hour;
    logic [NUM_SLOTS-1:0][2:0] s_dow;
    logic [NUM_SLOTS-1:0][3:0] s_mask;
    logic [NUM_SLOTS-1:0]      s_en;

    logic wr_ok, ack_ok, match;

    assign wr_ok  = wr_en_i && (int'(wr_slot_i) < NUM_SLOTS);
    assign ack_ok = ack_i && (int'(ack_slot_i) < NUM_SLOTS);

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        alarm_slot u_slot (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .wr_i        (wr_ok && (int'(wr_slot_i) == g)),
            .wr_sec_i    (wr_sec_i),
            .wr_min_i    (wr_min_i),
            .wr_hour_i   (wr_hour_i),
            .wr_dow_i    (wr_day_of_week_i),
            .wr_mask_i   (wr_mask_i),
            .wr_enable_i (wr_enable_i),
            .sec_o       (s_sec[g]),
            .min_o       (s_min[g]),
            .hour_o      (s_hour[g]),
            .dow_o       (s_dow[g]),
            .mask_o      (s_mask[g]),
            .en_o        (s_en[g])
        );
    end

`ifdef ALARM_SCHED_DOW_EN
    logic [2:0] snap_dow_q, snap_dow_d;

    // Weekday snapshot taken with the rest of the time at scan start
    always_comb begin
        snap_dow_d = snap_dow_q;
        if (state_q == IDLE && sec_tick_i) snap_dow_d = cur_day_of_week_i;
    end

    // Weekday snapshot register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) snap_dow_q <= '0;
        else       snap_dow_q <= snap_dow_d;
    end

    assign snap_dow = snap_dow_q;
`else
    logic unused_cur_dow;
    assign unused_cur_dow = ^cur_day_of_week_i;
    assign snap_dow = '0;
`endif

    // Shared comparator against the slot selected by the scan index
    always_comb begin
        match = (state_q == SCAN) && s_en[idx_q] &&
                (s_mask[idx_q][0] || s_sec[idx_q]  == snap_sec_q)  &&
                (s_mask[idx_q][1] || s_min[idx_q]  == snap_min_q)  &&
                (s_mask[idx_q][2] || s_hour[idx_q] == snap_hour_q) &&
                (s_mask[idx_q][3] || s_dow[idx_q]  == snap_dow);
    end

    // Scan FSM: snapshot on tick, walk every slot once, flag dropped ticks
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        overrun_d   = overrun_q;
        snap_sec_d  = snap_sec_q;
        snap_min_d  = snap_min_q;
        snap_hour_d = snap_hour_q;
        case (state_q)
            IDLE: begin
                if (sec_tick_i) begin
                    state_d     = SCAN;
                    idx_d       = '0;
                    snap_sec_d  = cur_sec_i;
                    snap_min_d  = cur_min_i;
                    snap_hour_d = cur_hour_i;
                end
            end
            SCAN: begin
                if (sec_tick_i) overrun_d = 1'b1;
                if (idx_q == SLOT_W'(NUM_SLOTS - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending flags: ack clear < compare set < write clear
    always_comb begin
        pending_d = pending_q;
        if (ack_ok) pending_d[ack_slot_i] = 1'b0;
        if (match)  pending_d[idx_q]      = 1'b1;
        if (wr_ok)  pending_d[wr_slot_i]  = 1'b0;
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pending_q   <= '0;
            overrun_q   <= 1'b0;
            snap_sec_q  <= '0;
            snap_min_q  <= '0;
            snap_hour_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            snap_sec_q  <= snap_sec_d;
            snap_min_q  <= snap_min_d;
            snap_hour_q <= snap_hour_d;
        end
    end

    // Lowest-index pending slot; 0 when nothing is pending
    always_comb begin
        irq_slot_o = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pending_q[i]) irq_slot_o = SLOT_W'(i);
        end
    end

    assign irq_o     = |pending_q;
    assign pending_o = pending_q;
    assign busy_o    = (state_q == SCAN);
    assign overrun_o = overrun_q;
endmodule
